// File: rtl/def_pin_pkg.sv
// Shared types and LFSR helpers for the DEF pin-test sequencer/checker.
package def_pin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Galois right-shift step for x^8+x^6+x^5+x^4+1.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/def_pin_seq_checker_if.sv
// Control/status and pin-test signals between the checker and its environment.
interface def_pin_seq_checker_if #(
  parameter int ERR_W = 8,
  parameter int IDX_W = 5
);
  logic             start;
  logic             abort;
  logic             dut_in;
  logic             dut_out;
  logic             dut_tied;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] vec_idx;

  modport master (
    output start, abort, dut_out, dut_tied,
    input  dut_in, busy, done, pass, err_count, vec_idx
  );

  modport slave (
    input  start, abort, dut_out, dut_tied,
    output dut_in, busy, done, pass, err_count, vec_idx
  );
endinterface

// File: rtl/def_pin_lfsr8.sv
// 8-bit Galois LFSR stimulus source; load reseeds, step advances one position.
module def_pin_lfsr8
  import def_pin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)      q_d = LFSR_SEED;
    else if (step) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= LFSR_SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/def_pin_seq_checker.sv
// Drives LFSR stimulus into the pin-test inverter, waits a settle time, samples
// the inverted and tie-high returns and counts mismatching vectors.
module def_pin_seq_checker
  import def_pin_pkg::*;
#(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  def_pin_seq_checker_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_VECTORS) + 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dut_in_q, dut_in_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             ret_out_q, ret_tied_q;
  logic             lfsr_load, lfsr_step;
  logic [7:0]       lfsr_q;
  logic             stim_bit;
  logic             mismatch;

  def_pin_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .q     (lfsr_q)
  );

  assign stim_bit = (lfsr_q & 8'h01) != 8'h00;

  // Returns are compared from their registered copies, captured at the end of settle.
  assign mismatch = (ret_out_q != ~dut_in_q) || (ret_tied_q != 1'b1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    idx_d     = idx_q;
    dut_in_d  = dut_in_q;
    pass_d    = pass_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = ST_DRIVE;
          err_d     = '0;
          idx_d     = '0;
          pass_d    = 1'b0;
          lfsr_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        dut_in_d = stim_bit;
        cnt_d    = '0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SAMPLE: begin
        lfsr_step = 1'b1;
        if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_DRIVE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort overrides everything; counters are frozen for post-mortem.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      dut_in_d  = 1'b0;
      pass_d    = 1'b0;
      err_d     = err_q;
      idx_d     = idx_q;
      lfsr_step = 1'b0;
    end

    busy_d = state_d inside {ST_DRIVE, ST_SETTLE, ST_SAMPLE};
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= '0;
      idx_q      <= '0;
      dut_in_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      ret_out_q  <= 1'b0;
      ret_tied_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      dut_in_q   <= dut_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      ret_out_q  <= bus.dut_out;
      ret_tied_q <= bus.dut_tied;
    end
  end

  assign bus.dut_in    = dut_in_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.vec_idx   = idx_q;

endmodule

// File: tb/tb_def_pin_seq_checker.sv
// Randomized bench: a behavioural pin-test datapath with per-vector fault injection
// and a run-level model (LFSR bit list, timing windows, mismatch count).
module tb_def_pin_seq_checker;

  localparam int NV   = 16;
  localparam int SC   = 2;
  localparam int VLEN = SC + 2;
  localparam int RUN  = NV * VLEN + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   mode = 0;
  bit   fault_now = 1'b0;

  int checks = 0;
  int fails  = 0;
  bit exp_bit [NV];
  bit last_pass = 1'b0;

  always #5 clk = ~clk;

  def_pin_seq_checker_if #(.ERR_W(8), .IDX_W(5)) bus_a ();
  def_pin_seq_checker_if #(.ERR_W(3), .IDX_W(5)) bus_b ();

  // Pin-test datapath model: inverter + tie-high, with selectable faults.
  assign bus_a.start    = start;
  assign bus_a.abort    = abort;
  assign bus_a.dut_out  = (mode == 1) ? bus_a.dut_in : (~bus_a.dut_in ^ fault_now);
  assign bus_a.dut_tied = (mode != 2);
  assign bus_b.start    = start;
  assign bus_b.abort    = abort;
  assign bus_b.dut_out  = bus_b.dut_in;
  assign bus_b.dut_tied = 1'b1;

  def_pin_seq_checker #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  def_pin_seq_checker #(.NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .ERR_W(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void build_model();
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < NV; k++) begin
      exp_bit[k] = l[0];
      l = {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from start acceptance. abort_c/rst_c/xstart_c are run-cycle numbers (0 = unused).
  task automatic run(input int md, input logic [NV-1:0] mask, input int abort_c,
                     input int rst_c, input int xstart_c);
    int errs;
    int exp_err;
    errs = 0;
    mode = md;
    fault_now = 1'b0;
    for (int k = 0; k < NV; k++)
      if (md == 1 || md == 2 || mask[k]) errs++;
    exp_err = (errs > 255) ? 255 : errs;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pass_clr", bus_a.pass, 0);
    chk("err_clr", bus_a.err_count, 0);
    for (int c = 1; c <= RUN + 2; c++) begin
      int v;
      int p;
      v = (c - 1) / VLEN;
      p = (c - 1) % VLEN;
      fault_now = (c < RUN) ? mask[v] : 1'b0;
      start = (c == xstart_c);
      if (abort_c > 0 && c == abort_c + 1) begin
        abort = 1'b0;
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_dut_in", bus_a.dut_in, 0);
        chk("abort_done", bus_a.done, 0);
        chk("abort_pass", bus_a.pass, 0);
        chk("abort_vec_idx", bus_a.vec_idx, (abort_c - 1) / VLEN);
        chk("abort_err", bus_a.err_count, 0);
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("abort_no_done", bus_a.done, 0);
          chk("abort_idle", bus_a.busy, 0);
        end
        last_pass = 1'b0;
        return;
      end
      if (abort_c > 0 && c == abort_c) abort = 1'b1;
      if (rst_c > 0 && c == rst_c) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", bus_a.busy, 0);
        chk("rst_dut_in", bus_a.dut_in, 0);
        chk("rst_err", bus_a.err_count, 0);
        chk("rst_vec_idx", bus_a.vec_idx, 0);
        chk("rst_pass", bus_a.pass, 0);
        chk("rst_done", bus_a.done, 0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
          tick();
          chk("rst_no_done", bus_a.done, 0);
          chk("rst_idle", bus_a.busy, 0);
        end
        last_pass = 1'b0;
        return;
      end
      if (c < RUN) begin
        chk($sformatf("busy c%0d", c), bus_a.busy, 1);
        chk($sformatf("done c%0d", c), bus_a.done, 0);
        if (p == VLEN - 1) begin
          chk($sformatf("dut_in v%0d", v), bus_a.dut_in, exp_bit[v]);
          chk($sformatf("vec_idx v%0d", v), bus_a.vec_idx, v);
        end
      end else if (c == RUN) begin
        chk("done_pulse", bus_a.done, 1);
        chk("done_busy", bus_a.busy, 0);
        chk("done_pass", bus_a.pass, exp_err == 0);
        chk("done_err", bus_a.err_count, exp_err);
        chk("done_vec_idx", bus_a.vec_idx, NV - 1);
        chk("sat_err_b", bus_b.err_count, 7);
        chk("sat_pass_b", bus_b.pass, 0);
      end else begin
        chk($sformatf("post_done c%0d", c), bus_a.done, 0);
        chk($sformatf("post_busy c%0d", c), bus_a.busy, 0);
        chk($sformatf("post_pass c%0d", c), bus_a.pass, exp_err == 0);
      end
      tick();
    end
    start = 1'b0;
    last_pass = (exp_err == 0);
  endtask

  initial begin
    build_model();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dut_in", bus_a.dut_in, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_pass", bus_a.pass, 0);
    chk("rst_err", bus_a.err_count, 0);
    chk("rst_vec_idx", bus_a.vec_idx, 0);
    rst_n = 1'b1;
    tick();

    run(0, '0, 0, 0, 10);                  // golden, start while busy
    run(1, '0, 0, 0, 0);                   // buffer instead of inverter
    run(2, '0, 0, 0, 0);                   // tie-high stuck at 0
    for (int r = 0; r < 4; r++)
      run(0, NV'($urandom), 0, 0, $urandom_range(2, RUN));
    run(0, '0, 5 * VLEN + 2, 0, 0);        // abort in SETTLE of vector 5
    run(0, '0, 0, 0, RUN);                 // clean rerun, start during DONE

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_start_abort_busy", bus_a.busy, 0);
      chk("idle_start_abort_pass", bus_a.pass, last_pass);
      tick();
    end

    run(0, NV'($urandom), 0, 30, 0);       // async reset mid-run
    run(0, NV'($urandom), 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
